// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Imported by the interface and the unit itself.
package muldiv_pkg;

    localparam int MD_DATA_W = 16;
    localparam int MD_ADDR_W = 3;
    localparam int ITER_CNT  = MD_DATA_W;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVQ  = 2'b10,
        OP_DIVR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request and register-file write-back bundle for muldiv_unit.
// Control drives the request side; the unit drives status and write port.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int ADDR_W = MD_ADDR_W
) ();

    logic              start;
    op_e               op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [ADDR_W-1:0] dest_addr;
    logic              busy;
    logic              done;
    logic              reg_write;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              div_by_zero;

    modport master (
        output start, op, src_a, src_b, dest_addr,
        input  busy, done, reg_write, wr_addr, wr_data, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, dest_addr,
        output busy, done, reg_write, wr_addr, wr_data, div_by_zero
    );

endinterface

// File: rtl/muldiv_unit.sv
// Unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Retires its result through the register-file write port in one WB cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int ADDR_W = MD_ADDR_W
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int WORK_W = 2 * DATA_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [WORK_W-1:0] work_q, work_d;

    logic [DATA_W:0]   add_a;
    logic [DATA_W:0]   add_b;
    logic              add_sub;
    logic [DATA_W+1:0] add_sum;
    logic              wb;

    // One adder serves both: add for multiply, a + ~b + 1 for divide.
    always_comb begin
        add_sum = {1'b0, add_a}
                + {1'b0, (add_sub ? ~add_b : add_b)}
                + (DATA_W+2)'(add_sub);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        dest_d  = dest_q;
        work_d  = work_q;
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    b_d     = bus.src_b;
                    dest_d  = bus.dest_addr;
                    cnt_d   = '0;
                    work_d  = {(DATA_W+1)'(0), bus.src_a};
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_WB;
                end
                if (op_q[1]) begin
                    // Partial remainder shifted left with next dividend bit.
                    add_a   = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
                    add_b   = {1'b0, b_q};
                    add_sub = 1'b1;
                    if (add_sum[DATA_W+1]) begin
                        work_d = {add_sum[DATA_W:0],
                                  work_q[DATA_W-2:0], 1'b1};
                    end else begin
                        work_d = {add_a, work_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    add_a  = work_q[2*DATA_W:DATA_W];
                    add_b  = work_q[0] ? {1'b0, b_q} : '0;
                    work_d = {1'b0, add_sum[DATA_W:0],
                              work_q[DATA_W-1:1]};
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULLO;
            b_q     <= '0;
            dest_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            dest_q  <= dest_d;
            work_q  <= work_d;
        end
    end

    // High half holds MULHI / remainder, low half MULLO / quotient.
    always_comb begin
        wb              = (state_q == ST_WB);
        bus.busy        = (state_q != ST_IDLE);
        bus.done        = wb;
        bus.reg_write   = wb;
        bus.wr_addr     = wb ? dest_q : '0;
        bus.wr_data     = '0;
        if (wb) begin
            bus.wr_data = op_q[0] ? work_q[2*DATA_W-1:DATA_W]
                                  : work_q[DATA_W-1:0];
        end
        bus.div_by_zero = wb && op_q[1] && (b_q == '0);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vectors plus capture, reset-abort and back-to-back sequences
// for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        op_e         op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic [15:0] exp_data;
        logic        exp_dbz;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int inj, input string tag);
        int          n_wr   = 0;
        int          n_busy = 0;
        int          wr_cyc = -1;
        logic [15:0] got_d  = '0;
        logic [2:0]  got_a  = '0;
        logic        got_z  = 1'b0;
        logic        got_dn = 1'b0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = v.op;
        bus.src_a     = v.a;
        bus.src_b     = v.b;
        bus.dest_addr = v.dest;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.op        = OP_DIVR;
        bus.src_a     = 16'hDEAD;
        bus.src_b     = 16'h0000;
        bus.dest_addr = 3'd6;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus.busy) n_busy++;
            if (bus.reg_write) begin
                n_wr++;
                wr_cyc = c;
                got_d  = bus.wr_data;
                got_a  = bus.wr_addr;
                got_z  = bus.div_by_zero;
                got_dn = bus.done;
            end
            if (c == inj) begin
                bus.start     = 1'b1;
                bus.op        = OP_MULHI;
                bus.src_a     = 16'h0001;
                bus.src_b     = 16'h0001;
                bus.dest_addr = 3'd7;
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, " write_count"}, n_wr, 1);
        check({tag, " write_cycle"}, wr_cyc, 17);
        check({tag, " wr_addr"}, got_a, v.dest);
        check({tag, " wr_data"}, got_d, v.exp_data);
        check({tag, " div_by_zero"}, got_z, v.exp_dbz);
        check({tag, " done"}, got_dn, 1);
        check({tag, " busy_cycles"}, n_busy, 17);
    endtask

    initial begin
        vec_t vecs[11];
        vec_t rv;
        int   q[$];
        int   n_wr;
        int   n_busy;

        vecs[0]  = '{OP_MULLO, 16'd300,  16'd200,  3'd3, 16'hEA60, 1'b0};
        vecs[1]  = '{OP_MULHI, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFE, 1'b0};
        vecs[2]  = '{OP_MULLO, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 1'b0};
        vecs[3]  = '{OP_DIVQ,  16'd69,   16'd5,    3'd4, 16'h000D, 1'b0};
        vecs[4]  = '{OP_DIVR,  16'd69,   16'd5,    3'd5, 16'h0004, 1'b0};
        vecs[5]  = '{OP_DIVQ,  16'd1234, 16'd0,    3'd6, 16'hFFFF, 1'b1};
        vecs[6]  = '{OP_DIVR,  16'd1234, 16'd0,    3'd7, 16'h04D2, 1'b1};
        vecs[7]  = '{OP_MULHI, 16'h1234, 16'h5678, 3'd1, 16'h0626, 1'b0};
        vecs[8]  = '{OP_MULLO, 16'h1234, 16'h5678, 3'd2, 16'h0060, 1'b0};
        vecs[9]  = '{OP_DIVQ,  16'hFFFF, 16'd1,    3'd0, 16'hFFFF, 1'b0};
        vecs[10] = '{OP_DIVR,  16'd7,    16'd9,    3'd0, 16'h0007, 1'b0};

        bus.start     = 1'b0;
        bus.op        = OP_MULLO;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.dest_addr = '0;

        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset reg_write", bus.reg_write, 0);
        check("reset wr_addr", bus.wr_addr, 0);
        check("reset wr_data", bus.wr_data, 0);
        check("reset div_by_zero", bus.div_by_zero, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Start pulse in RUN cycle 5 must be ignored.
        rv = vecs[0];
        run_op(rv, 5, "ignored_start");

        // Asynchronous reset during RUN cycle 8 aborts the operation.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = OP_MULLO;
        bus.src_a     = 16'd300;
        bus.src_b     = 16'd200;
        bus.dest_addr = 3'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) @(negedge clk);
        check("pre_abort busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort reg_write", bus.reg_write, 0);
        check("abort done", bus.done, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_wr   = 0;
        n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.reg_write) n_wr++;
            if (bus.busy) n_busy++;
        end
        check("post_abort writes", n_wr, 0);
        check("post_abort busy", n_busy, 0);

        // Start held high: one retire every 18 cycles.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = OP_MULLO;
        bus.src_a     = 16'd2;
        bus.src_b     = 16'd3;
        bus.dest_addr = 3'd5;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.reg_write) begin
                q.push_back(c);
                check("b2b wr_data", bus.wr_data, 16'd6);
                check("b2b wr_addr", bus.wr_addr, 3'd5);
            end
        end
        bus.start = 1'b0;
        check("b2b pulse_count", q.size(), 3);
        for (int i = 1; i < q.size(); i++) begin
            check("b2b spacing", q[i] - q[i-1], 18);
        end
        repeat (20) @(negedge clk);
        check("final idle busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle unsigned multiply/divide unit for the 16-bit MIPS datapath, directly downstream of `register_file`. It consumes the two read-port values (`data1`, `data2`) as operands. It iterates for 16 cycles, then drives the register file's write port (`sig_regWrite`, `wr_addr`, `wr_data`) for exactly one cycle to retire the result. Control sequences instructions around the busy interval; the unit performs no hazard handling itself.

## Interface
- `DATA_W`, 16, operand/result width; the iteration count equals `DATA_W`.
- `ADDR_W`, 3, register address width (8 registers).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MULLO, 01 MULHI, 10 DIVQ (quotient), 11 DIVR (remainder).
- `src_a`  in  DATA_W  multiplicand/dividend (from `data1`).
- `src_b`  in  DATA_W  multiplier/divisor (from `data2`).
- `dest_addr`  in  ADDR_W  destination register.
- `busy`  out  1  high from the cycle after accept through the WB cycle.
- `done`  out  1  one-cycle pulse in the WB cycle.
- `reg_write`  out  1  to register file `sig_regWrite`; high only in WB.
- `wr_addr`  out  ADDR_W  to register file `wr_addr`; 0 when `reg_write`=0.
- `wr_data`  out  DATA_W  to register file `wr_data`; 0 when `reg_write`=0.
- `div_by_zero`  out  1  high with `done` when `op[1]`=1 and `src_b`=0.

## Operation
- FSM states:
  - IDLE: on `start`=1, capture `op`, `src_a`, `src_b` and `dest_addr`; clear the 5-bit counter; go to RUN.
  - RUN: one iteration per cycle; after the 16th iteration (counter = 15) go to WB.
  - WB: assert `reg_write`, `done`, `wr_addr`=captured dest and `wr_data`=selected result; go to IDLE unconditionally.
- Operands are captured at accept; input changes afterwards have no effect.
- `start` in RUN or WB is ignored. It is not queued.
- Multiply: shift-add over a 32-bit product register (`{hi,lo}`). Each step adds `src_b` to `hi` when `lo[0]`=1, then shifts right by 1, keeping the carry. MULLO returns `product[15:0]` and MULHI returns `product[31:16]`.
- Divide: unsigned restoring division over a 17-bit partial remainder and a 16-bit quotient, MSB first.
  - Divisor = 0 is not special-cased in the datapath. The natural result is quotient 0xFFFF and remainder = `src_a`.
  - `div_by_zero` is derived from the captured `src_b`=0 and `op[1]`=1.
  - Latency is unchanged for divide-by-zero.
- `dest_addr` = 0 is written like any other address; r0 policy belongs to the register file.
- All arithmetic is unsigned; there is no signed mode and no overflow flag.

## Timing
- Reset (asynchronous, `rst_n`=0) sets:
  - state IDLE;
  - `busy`, `done`, `reg_write`, `div_by_zero` = 0;
  - `wr_addr` = 0, `wr_data` = 0;
  - all internal registers = 0.
- Reset mid-RUN or mid-WB aborts the operation. No write is issued and outputs clear immediately, without waiting for a clock edge.
- Latency: `start` is sampled at edge E0, and `reg_write`/`done` are high for the one cycle between E16 and E17. The write commits at E17, 17 edges after accept.
- `busy` is high between E0 and E17 (17 cycles).
- Throughput: with `start` held high, accepts occur every 18 cycles, because the IDLE cycle after WB is mandatory.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings `OP_MULLO`, `OP_MULHI`, `OP_DIVQ`, `OP_DIVR`;
  - state encoding `ST_IDLE`, `ST_RUN`, `ST_WB`;
  - `ITER_CNT` = 16.
- Single module with no sub-module: one FSM, one shared counter, and one shared 33-bit working register. The multiply and divide steps reuse the same adder/subtractor.

## Test plan
- MULLO `src_a`=300, `src_b`=200, `dest_addr`=3 -> at E16–E17: `reg_write`=1, `wr_addr`=3, `wr_data`=0xEA60, `div_by_zero`=0; `busy` high for exactly 17 cycles.
- MULHI 0xFFFF × 0xFFFF -> `wr_data`=0xFFFE; MULLO with the same operands -> 0x0001.
- DIVQ 69 / 5 -> `wr_data`=0x000D; DIVR 69 / 5 -> 0x0004; `div_by_zero`=0 in both cases.
- DIVQ 1234 / 0 -> `wr_data`=0xFFFF with `div_by_zero`=1; DIVR 1234 / 0 -> 0x04D2 with `div_by_zero`=1.
- Robustness: pulse `start` with new operands in RUN cycle 5 -> ignored, and the original result is written. Then drive `rst_n`=0 in RUN cycle 8 -> `busy`=0 immediately, and no `reg_write` occurs in the following 20 cycles.
- Hold `start`=1 continuously with MULLO 2×3 -> `reg_write` pulses carrying 6 appear exactly 18 cycles apart.
